button_event_fsm: RTL and testbench
===================================

Name: button_event_fsm

Overview:
Consumes the debounced, already-synchronous level from the button debouncer and classifies it into single-cycle event pulses: press, release, short press, long press, double click and optional auto-repeat. Sits between the debouncer stage and the lab's control and display logic. All outputs are registered.

Parameters:
LONG_CYCLES, 100_000_000, hold time for long press (1 s @ 100 MHz); must be >= 2
GAP_CYCLES, 30_000_000, maximum release-to-second-press gap for a double click (300 ms); must be >= 2
REPEAT_CYCLES, 20_000_000, auto-repeat period once long press is reached (200 ms); must be >= 2

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
btn_in  input  1  debounced button level (1 = pressed), synchronous to clk
held  output  1  registered copy of btn_in
press_pulse  output  1  one-cycle pulse on each press
release_pulse  output  1  one-cycle pulse on each release
short_press  output  1  one-cycle pulse: single click confirmed
long_press  output  1  one-cycle pulse: hold reached LONG_CYCLES
double_click  output  1  one-cycle pulse: second click released
repeat_pulse  output  1  one-cycle auto-repeat pulse (see Optional Feature)

Behaviour:
- Reset is asserted by reset_n, asynchronous, active-low; clock is clk. While reset is asserted: all outputs 0, btn_q = 0, state IDLE, counters 0.
- Edge detection uses btn_q (the held register). rise = btn_in & ~btn_q; fall = ~btn_in & btn_q.
- If btn_in = 1 at reset release, a rise is detected on the first clock edge.
- Latency: every output updates on the clock edge at which the causing condition is sampled. press_pulse and release_pulse appear in cycle P/R, where btn_in is first sampled high/low.
- A single counter of width $clog2(max(LONG_CYCLES, GAP_CYCLES, REPEAT_CYCLES)) + 1 clears on every state change.
- States:
  - IDLE: on rise, emit press_pulse and go to PRESSED.
  - PRESSED: the counter increments each held cycle.
    - On fall: emit release_pulse and go to WAIT_SECOND.
    - Else, when the counter reaches LONG_CYCLES-1: emit long_press and go to LONG_HELD. long_press therefore fires at cycle P+LONG_CYCLES.
  - LONG_HELD: on fall, emit release_pulse and go to IDLE. No short_press or double_click is ever emitted from this state.
  - WAIT_SECOND: the counter increments.
    - On rise: emit press_pulse and go to SECOND_PRESSED.
    - Else, when the counter reaches GAP_CYCLES-1: emit short_press and go to IDLE. short_press therefore fires at cycle R+GAP_CYCLES.
  - SECOND_PRESSED: the counter increments.
    - On fall: emit release_pulse and double_click in the same cycle, then go to IDLE.
    - Else, at LONG_CYCLES-1: emit long_press and go to LONG_HELD. The first click is discarded; no short_press.
- Simultaneous events:
  - Fall beats the long threshold in the same cycle.
  - Rise beats the gap timeout in the same cycle.
- At most one of short_press, long_press and double_click is high in any cycle.
- Reset asserted mid-sequence aborts it. No pending short_press is emitted afterwards.

Optional Feature:
Macro BTN_AUTO_REPEAT_EN.
- Defined: in LONG_HELD the counter runs modulo REPEAT_CYCLES. repeat_pulse fires at cycle L+k*REPEAT_CYCLES (k >= 1), where L is the long_press cycle, while held. It stops on fall, and a fall in the same cycle suppresses the pulse.
- Undefined: repeat_pulse is tied 0, REPEAT_CYCLES is unused, and the counter holds in LONG_HELD.

Test Plan:
(Test parameters: LONG_CYCLES=8, GAP_CYCLES=5, REPEAT_CYCLES=3.)
1. Reset, btn_in=0 for 20 cycles -> all outputs 0 throughout.
2. Press at P for 3 cycles, then release (R=P+3), idle 10 cycles -> press_pulse@P, release_pulse@R, short_press@R+5 only.
3. Hold from P for 20 cycles -> long_press@P+8; release_pulse at release; no short_press or double_click afterwards. Also a hold of exactly 8 cycles (fall sampled at P+8) -> no long_press, and short_press@P+13.
4. Press 2 cycles, release 2, press 2, release -> two press_pulses; double_click coincident with the second release_pulse; no short_press.
5. With BTN_AUTO_REPEAT_EN defined, hold 20 cycles from P -> repeat_pulse@P+11, P+14, P+17, P+20-if-still-held; none after release. Undefined -> repeat_pulse always 0.
6. Press/release, then assert reset_n=0 two cycles into WAIT_SECOND -> all outputs 0 immediately; no short_press after reset release with btn_in=0.

Source files
------------

// File: rtl/button_event_fsm_if.sv
// Button event bundle: debounced level in, registered event pulses out.
interface button_event_fsm_if;
    logic btn_in;
    logic held;
    logic press_pulse;
    logic release_pulse;
    logic short_press;
    logic long_press;
    logic double_click;
    logic repeat_pulse;

    modport master (
        output btn_in,
        input  held, press_pulse, release_pulse, short_press,
               long_press, double_click, repeat_pulse
    );

    modport slave (
        input  btn_in,
        output held, press_pulse, release_pulse, short_press,
               long_press, double_click, repeat_pulse
    );
endinterface

// File: rtl/button_event_fsm.sv
// Classifies a debounced button level into press/release/short/long/double/repeat pulses.
// Optional auto-repeat while long-held is enabled by defining BTN_AUTO_REPEAT_EN.
module button_event_fsm #(
    parameter int LONG_CYCLES   = 100_000_000,
    parameter int GAP_CYCLES    = 30_000_000,
    parameter int REPEAT_CYCLES = 20_000_000
) (
    input  logic              clk,
    input  logic              reset_n,
    button_event_fsm_if.slave bus
);
    localparam int MAX_LG  = (LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES;
    localparam int MAX_ALL = (MAX_LG > REPEAT_CYCLES) ? MAX_LG : REPEAT_CYCLES;
    localparam int CW      = $clog2(MAX_ALL) + 1;

    typedef enum logic [2:0] {
        IDLE,
        PRESSED,
        LONG_HELD,
        WAIT_SECOND,
        SECOND_PRESSED
    } state_t;

    state_t         state, state_nx;
    logic [CW-1:0]  cnt, cnt_nx;
    logic           btn_q;
    logic           rise, fall;
    logic           short_nx, long_nx, dbl_nx, rep_nx;

    assign rise = bus.btn_in & ~btn_q;
    assign fall = ~bus.btn_in & btn_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            cnt               <= '0;
            btn_q             <= 1'b0;
            bus.held          <= 1'b0;
            bus.press_pulse   <= 1'b0;
            bus.release_pulse <= 1'b0;
            bus.short_press   <= 1'b0;
            bus.long_press    <= 1'b0;
            bus.double_click  <= 1'b0;
            bus.repeat_pulse  <= 1'b0;
        end else begin
            state             <= state_nx;
            cnt               <= cnt_nx;
            btn_q             <= bus.btn_in;
            bus.held          <= bus.btn_in;
            bus.press_pulse   <= rise;
            bus.release_pulse <= fall;
            bus.short_press   <= short_nx;
            bus.long_press    <= long_nx;
            bus.double_click  <= dbl_nx;
            bus.repeat_pulse  <= rep_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        short_nx = 1'b0;
        long_nx  = 1'b0;
        dbl_nx   = 1'b0;
        rep_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (rise) state_nx = PRESSED;
            end
            PRESSED: begin
                // Fall takes priority over reaching the long threshold.
                if (fall) begin
                    state_nx = WAIT_SECOND;
                end else if (cnt == CW'(LONG_CYCLES - 1)) begin
                    long_nx  = 1'b1;
                    state_nx = LONG_HELD;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            LONG_HELD: begin
                if (fall) begin
                    state_nx = IDLE;
                end else begin
`ifdef BTN_AUTO_REPEAT_EN
                    if (cnt == CW'(REPEAT_CYCLES - 1)) begin
                        rep_nx = 1'b1;
                        cnt_nx = '0;
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
`else
                    cnt_nx = cnt;
`endif
                end
            end
            WAIT_SECOND: begin
                if (rise) begin
                    state_nx = SECOND_PRESSED;
                end else if (cnt == CW'(GAP_CYCLES - 1)) begin
                    short_nx = 1'b1;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            SECOND_PRESSED: begin
                if (fall) begin
                    dbl_nx   = 1'b1;
                    state_nx = IDLE;
                end else if (cnt == CW'(LONG_CYCLES - 1)) begin
                    long_nx  = 1'b1;
                    state_nx = LONG_HELD;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
        if (state_nx != state) cnt_nx = '0;
    end
endmodule

// File: tb/tb_button_event_fsm.sv
// Directed plus randomized bench for button_event_fsm, checked against a timestamp-based model.
module tb_button_event_fsm;
    localparam int LONG = 8;
    localparam int GAP  = 5;
    localparam int REP  = 3;
`ifdef BTN_AUTO_REPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    button_event_fsm_if bus ();

    button_event_fsm #(
        .LONG_CYCLES   (LONG),
        .GAP_CYCLES    (GAP),
        .REPEAT_CYCLES (REP)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    // Model: timestamps of the current press, pending release and long-hold start.
    int   n;
    int   press_t, rel_t, long_t;
    bit   second;
    logic mq;
    logic e_held, e_press, e_rel, e_short, e_long, e_dbl, e_rep;

    task automatic model_clear();
        press_t = -1; rel_t = -1; long_t = -1; second = 1'b0; mq = 1'b0;
        e_held = 0; e_press = 0; e_rel = 0; e_short = 0; e_long = 0; e_dbl = 0; e_rep = 0;
    endtask

    task automatic model_step(input logic b);
        logic rise, fall;
        rise = b & ~mq;
        fall = ~b & mq;
        e_held = b; e_press = rise; e_rel = fall;
        e_short = 0; e_long = 0; e_dbl = 0; e_rep = 0;
        if (long_t >= 0) begin
            if (fall) long_t = -1;
            else if (AUTO && n > long_t && ((n - long_t) % REP) == 0) e_rep = 1;
        end else if (press_t >= 0) begin
            if (fall) begin
                if (second) e_dbl = 1;
                else rel_t = n;
                press_t = -1;
            end else if (n - press_t == LONG) begin
                e_long = 1; long_t = n; press_t = -1;
            end
        end else if (rel_t >= 0) begin
            if (rise) begin
                press_t = n; second = 1; rel_t = -1;
            end else if (n - rel_t == GAP) begin
                e_short = 1; rel_t = -1;
            end
        end else if (rise) begin
            press_t = n; second = 0;
        end
        mq = b;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s cycle %0d observed=%b expected=%b", tag, n, obs, exp);
        end
    endtask

    task automatic check_all();
        check("held",          bus.held,          e_held);
        check("press_pulse",   bus.press_pulse,   e_press);
        check("release_pulse", bus.release_pulse, e_rel);
        check("short_press",   bus.short_press,   e_short);
        check("long_press",    bus.long_press,    e_long);
        check("double_click",  bus.double_click,  e_dbl);
        check("repeat_pulse",  bus.repeat_pulse,  e_rep);
    endtask

    task automatic cyc(input logic b);
        bus.btn_in = b;
        @(posedge clk);
        n++;
        model_step(b);
        @(negedge clk);
        check_all();
    endtask

    task automatic run(input logic b, input int len);
        for (int i = 0; i < len; i++) cyc(b);
    endtask

    task automatic apply_reset(input int cycles);
        reset_n = 1'b0;
        #1;
        model_clear();
        check_all();
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        n = 0;
        bus.btn_in = 1'b0;
        model_clear();
        #1;
        apply_reset(2);

        run(0, 20);                              // idle after reset
        run(1, 3);  run(0, 10);                  // short click
        run(1, 20); run(0, 12);                  // long hold (repeats if enabled)
        run(1, 8);  run(0, 15);                  // fall exactly at long threshold
        run(1, 2);  run(0, 2); run(1, 2); run(0, 10);  // double click
        run(1, 2);  run(0, 4); run(1, 12); run(0, 10); // second press goes long
        run(1, 3);  run(0, 5); run(1, 2); run(0, 10);  // rise exactly at gap timeout
        run(1, 2);  run(0, 2);                   // reset two cycles into gap wait
        apply_reset(2);
        run(0, 12);
        bus.btn_in = 1'b1;                       // held through reset release
        apply_reset(2);
        run(1, 3);  run(0, 10);

        for (int k = 0; k < 60; k++) begin
            run(1, $urandom_range(1, 14));
            run(0, $urandom_range(1, 8));
            if ($urandom_range(0, 14) == 0) apply_reset($urandom_range(1, 3));
        end
        run(0, 15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
